subbytes_sched: RTL and testbench

SUBBYTES_SCHED -- requirements
Module: subbytes_sched

---
 rtl/subbytes_sched_if.sv | 34 +++
 rtl/subbytes_sched.sv | 136 +++++++++++++
 tb/tb_subbytes_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/subbytes_sched_if.sv
// rtl/subbytes_sched_if.sv - request/ack/done and S-box bus bundle for subbytes_sched
//
// Signals:
//   st_req/st_in/st_ack/st_out/st_done : 128-bit state SubBytes job channel
//   wd_req/wd_in/wd_ack/wd_out/wd_done : 32-bit key-schedule SubWord job channel
//   sbox_a/sbox_c                      : shared combinational S-box lookup
//   busy                               : scheduler not idle
// Modports: master = requesters + S-box provider, slave = scheduler.

interface subbytes_sched_if;
    logic         st_req;
    logic [127:0] st_in;
    logic         st_ack;
    logic [127:0] st_out;
    logic         st_done;
    logic         wd_req;
    logic [31:0]  wd_in;
    logic         wd_ack;
    logic [31:0]  wd_out;
    logic         wd_done;
    logic [7:0]   sbox_a;
    logic [7:0]   sbox_c;
    logic         busy;

    modport master (
        output st_req, st_in, wd_req, wd_in, sbox_c,
        input  st_ack, st_out, st_done, wd_ack, wd_out, wd_done, sbox_a, busy
    );

    modport slave (
        input  st_req, st_in, wd_req, wd_in, sbox_c,
        output st_ack, st_out, st_done, wd_ack, wd_out, wd_done, sbox_a, busy
    );
endinterface

// File: rtl/subbytes_sched.sv
// rtl/subbytes_sched.sv - arbitrates state/word SubBytes jobs onto one shared S-box
//
// Parameters:
//   PRIO_FIX : 0 = round-robin on ties, 1 = word requester always wins ties
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : subbytes_sched_if.slave (job channels, S-box bus, busy)

module subbytes_sched #(
    parameter int PRIO_FIX = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    subbytes_sched_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB_ST = 2'd1,
        SUB_WD = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic FIX = (PRIO_FIX != 0);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic         last_wd_q, last_wd_d;     // 1 = word requester was granted last
    logic [127:0] st_out_q, st_out_d;
    logic [31:0]  wd_out_q, wd_out_d;
    logic         st_done_q, st_done_d;
    logic         wd_done_q, wd_done_d;

    logic         idle;
    logic         grant_wd;
    logic         grant_st;
    logic         st_ack;
    logic         wd_ack;
    logic         last_byte;
    logic [6:0]   byte_lsb;

    assign idle     = (state_q == IDLE);
    // Word wins if alone, if fixed priority, or if state was served last.
    assign grant_wd = bus.wd_req & (~bus.st_req | FIX | ~last_wd_q);
    assign grant_st = bus.st_req & ~grant_wd;
    // Acks are decided in the IDLE cycle itself so a grant costs no extra cycle;
    // gating with rst_n keeps them quiet while reset is asserted.
    assign st_ack   = idle & rst_n & grant_st;
    assign wd_ack   = idle & rst_n & grant_wd;

    assign byte_lsb  = {cnt_q, 3'b000};
    assign last_byte = (state_q == SUB_ST) ? (cnt_q == 4'd15) : (cnt_q == 4'd3);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        last_wd_d = last_wd_q;
        st_out_d  = st_out_q;
        wd_out_d  = wd_out_q;
        st_done_d = 1'b0;
        wd_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (st_ack) begin
                    work_d    = bus.st_in;
                    cnt_d     = 4'd0;
                    last_wd_d = 1'b0;
                    state_d   = SUB_ST;
                end else if (wd_ack) begin
                    work_d    = {96'd0, bus.wd_in};
                    cnt_d     = 4'd0;
                    last_wd_d = 1'b1;
                    state_d   = SUB_WD;
                end
            end
            SUB_ST, SUB_WD: begin
                work_d[byte_lsb +: 8] = bus.sbox_c;
                cnt_d                 = cnt_q + 4'd1;
                if (last_byte) begin
                    state_d = DONE;
                    // Result registers and done flags are loaded on the edge into
                    // DONE so that they are both visible during the DONE cycle.
                    if (state_q == SUB_ST) begin
                        st_out_d  = work_d;
                        st_done_d = 1'b1;
                    end else begin
                        wd_out_d  = work_d[31:0];
                        wd_done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            work_q    <= 128'd0;
            last_wd_q <= 1'b0;
            st_out_q  <= 128'd0;
            wd_out_q  <= 32'd0;
            st_done_q <= 1'b0;
            wd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            last_wd_q <= last_wd_d;
            st_out_q  <= st_out_d;
            wd_out_q  <= wd_out_d;
            st_done_q <= st_done_d;
            wd_done_q <= wd_done_d;
        end
    end

    assign bus.st_ack  = st_ack;
    assign bus.wd_ack  = wd_ack;
    assign bus.st_out  = st_out_q;
    assign bus.wd_out  = wd_out_q;
    assign bus.st_done = st_done_q;
    assign bus.wd_done = wd_done_q;
    assign bus.busy    = ~idle;
    assign bus.sbox_a  = (state_q == SUB_ST || state_q == SUB_WD) ? work_q[byte_lsb +: 8] : 8'h00;

endmodule

// File: tb/tb_subbytes_sched.sv
// tb/tb_subbytes_sched.sv - directed self-checking bench for subbytes_sched

module tb_subbytes_sched;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] VEC_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ALL63   = {16{8'h63}};

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    subbytes_sched_if ifc0 ();
    subbytes_sched_if ifc1 ();

    subbytes_sched #(.PRIO_FIX(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
    subbytes_sched #(.PRIO_FIX(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));

    always #5 clk = ~clk;

    assign ifc0.sbox_c = SBOX[8*(255 - int'(ifc0.sbox_a)) +: 8];
    assign ifc1.sbox_c = SBOX[8*(255 - int'(ifc1.sbox_a)) +: 8];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // State job on dut0: ack at c=0, busy c=1..17, done and result at c=17.
    task automatic run_state(input logic [127:0] din, input logic [127:0] dexp,
                             input logic [127:0] prev);
        @(negedge clk);
        ifc0.st_req = 1'b1;
        ifc0.st_in  = din;
        #1;
        check("st_ack_grant", 128'(ifc0.st_ack), 128'd1);
        check("sbox_a_idle", 128'(ifc0.sbox_a), 128'd0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ifc0.st_req = 1'b0;
                ifc0.st_in  = ~din;
            end
            #1;
            check("st_busy", 128'(ifc0.busy), 128'(c <= 17));
            check("st_done_time", 128'(ifc0.st_done), 128'(c == 17));
            check("st_ack_quiet", 128'(ifc0.st_ack), 128'd0);
            if (c == 1)  check("sbox_a_byte0", 128'(ifc0.sbox_a), 128'(din[7:0]));
            if (c == 16) check("sbox_a_byte15", 128'(ifc0.sbox_a), 128'(din[127:120]));
            if (c == 8)  check("st_out_hold", ifc0.st_out, prev);
            if (c >= 17) check("st_out_val", ifc0.st_out, dexp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ifc0.st_req = 1'b0; ifc0.st_in = '0; ifc0.wd_req = 1'b0; ifc0.wd_in = '0;
        ifc1.st_req = 1'b0; ifc1.st_in = '0; ifc1.wd_req = 1'b0; ifc1.wd_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_st_out", ifc0.st_out, 128'd0);
        check("rst_wd_out", 128'(ifc0.wd_out), 128'd0);
        check("rst_busy", 128'(ifc0.busy), 128'd0);
        check("rst_sbox_a", 128'(ifc0.sbox_a), 128'd0);
        check("rst_dones", 128'({ifc0.st_done, ifc0.wd_done}), 128'd0);
        check("rst_acks", 128'({ifc0.st_ack, ifc0.wd_ack}), 128'd0);
        rst_n = 1'b1;

        // All-zero state and the standard round-1 vector
        run_state(128'd0, ALL63, 128'd0);
        run_state(VEC_IN, VEC_OUT, ALL63);

        // Word job; a state request raised and dropped while busy starts nothing
        @(negedge clk);
        ifc0.wd_req = 1'b1;
        ifc0.wd_in  = 32'h00010203;
        #1;
        check("wd_ack_grant", 128'(ifc0.wd_ack), 128'd1);
        check("wd_st_ack_off", 128'(ifc0.st_ack), 128'd0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ifc0.wd_req = 1'b0;
                ifc0.wd_in  = 32'hffffffff;
                ifc0.st_req = 1'b1;
            end
            if (c == 3) ifc0.st_req = 1'b0;
            #1;
            check("wd_done_time", 128'(ifc0.wd_done), 128'(c == 5));
            check("wd_busy", 128'(ifc0.busy), 128'(c <= 5));
            check("wd_no_st_ack", 128'(ifc0.st_ack), 128'd0);
            check("wd_st_out_kept", ifc0.st_out, VEC_OUT);
            if (c >= 5) check("wd_out_val", 128'(ifc0.wd_out), 128'h637c777b);
        end

        // Tie handling: both requests held from reset release on both DUTs
        @(negedge clk);
        rst_n = 1'b0;
        ifc0.st_req = 1'b1; ifc0.wd_req = 1'b1; ifc0.st_in = '0; ifc0.wd_in = 32'h00010203;
        ifc1.st_req = 1'b1; ifc1.wd_req = 1'b1; ifc1.st_in = '0; ifc1.wd_in = 32'h00010203;
        #1;
        check("rst_ack_gated", 128'({ifc0.st_ack, ifc0.wd_ack, ifc1.st_ack, ifc1.wd_ack}), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c <= 24) begin
                check("rr_wd_ack", 128'(ifc0.wd_ack), 128'(c == 0 || c == 24));
                check("rr_st_ack", 128'(ifc0.st_ack), 128'(c == 6));
                check("rr_wd_done", 128'(ifc0.wd_done), 128'(c == 5));
                check("rr_st_done", 128'(ifc0.st_done), 128'(c == 23));
            end
            if (c == 23) check("rr_st_out", ifc0.st_out, ALL63);
            check("fix_wd_ack", 128'(ifc1.wd_ack), 128'(c % 6 == 0));
            check("fix_st_ack", 128'(ifc1.st_ack), 128'd0);
        end
        ifc0.st_req = 1'b0; ifc0.wd_req = 1'b0;
        ifc1.st_req = 1'b0; ifc1.wd_req = 1'b0;

        // Reset in the middle of a state job
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ifc0.st_req = 1'b1;
        ifc0.st_in  = VEC_IN;
        #1;
        check("abort_ack", 128'(ifc0.st_ack), 128'd1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) ifc0.st_req = 1'b0;
            #1;
            check("abort_busy", 128'(ifc0.busy), 128'd1);
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("abort_st_out", ifc0.st_out, 128'd0);
        check("abort_wd_out", 128'(ifc0.wd_out), 128'd0);
        check("abort_flags", 128'({ifc0.busy, ifc0.st_done, ifc0.wd_done, ifc0.st_ack, ifc0.wd_ack}), 128'd0);
        check("abort_sbox_a", 128'(ifc0.sbox_a), 128'd0);
        rst_n = 1'b1;
        for (int c = 10; c <= 20; c++) begin
            @(negedge clk); #1;
            check("abort_no_done", 128'({ifc0.st_done, ifc0.busy}), 128'd0);
        end
        run_state(VEC_IN, VEC_OUT, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
